// File: rtl/int_issue_queue_pkg.sv
`default_nettype none
// =============================================================================
// int_issue_queue_pkg : shared types for the integer issue queue
// Revision : 1.0
// =============================================================================
package int_issue_queue_pkg;

  localparam int ROB_ID_WIDTH   = 5;
  localparam int REG_DATA_WIDTH = 32;
  localparam int IIQ_N_ENTRIES  = 8;

  typedef logic [ROB_ID_WIDTH-1:0]   rob_id_t;
  typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;

  typedef struct packed {
    rob_id_t   instr_rob_id;
    logic      dst_valid;
    logic [3:0] alu_op;
    logic      src1_valid;
    logic      src1_ready;
    rob_id_t   src1_rob_id;
    reg_data_t src1_data;
    logic      src2_valid;
    logic      src2_ready;
    rob_id_t   src2_rob_id;
    reg_data_t src2_data;
  } iiq_entry_t;

endpackage
`default_nettype wire

// File: rtl/iiq_src_snoop.sv
`default_nettype none
// =============================================================================
// iiq_src_snoop : tag compare of one source operand against wakeup/broadcasts
// Revision : 1.0
// =============================================================================
module iiq_src_snoop
  import int_issue_queue_pkg::*;
(
  input  logic      i_src_valid,
  input  logic      i_src_ready,
  input  rob_id_t   i_src_rob_id,
  input  reg_data_t i_src_data,
  input  logic      i_wakeup_valid,
  input  rob_id_t   i_wakeup_rob_id,
  input  logic      i_alu_valid,
  input  rob_id_t   i_alu_rob_id,
  input  reg_data_t i_alu_data,
  input  logic      i_ld_valid,
  input  rob_id_t   i_ld_rob_id,
  input  reg_data_t i_ld_data,
  output logic      o_next_ready,
  output reg_data_t o_next_data
);

  logic w_wk_hit;
  logic w_alu_hit;
  logic w_ld_hit;

  assign w_wk_hit  = i_wakeup_valid && (i_wakeup_rob_id == i_src_rob_id);
  assign w_alu_hit = i_alu_valid    && (i_alu_rob_id    == i_src_rob_id);
  assign w_ld_hit  = i_ld_valid     && (i_ld_rob_id     == i_src_rob_id);

  assign o_next_ready = i_src_ready || (i_src_valid && (w_wk_hit || w_alu_hit || w_ld_hit));

  // ALU result wins over a load result carrying the same tag
  always_comb begin
    o_next_data = i_src_data;
    if (w_alu_hit) begin
      o_next_data = i_alu_data;
    end else if (w_ld_hit) begin
      o_next_data = i_ld_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/int_issue_queue.sv
`default_nettype none
// =============================================================================
// int_issue_queue : compacting, age-ordered integer issue queue with bypass
// Revision : 1.0
// =============================================================================
module int_issue_queue
  import int_issue_queue_pkg::*;
#(
  parameter int N_ENTRIES = IIQ_N_ENTRIES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iiq_dispatch_valid,
  output logic       iiq_dispatch_ready,
  input  iiq_entry_t iiq_dispatch_data,
  output logic       alu_issue_valid,
  input  logic       alu_issue_ready,
  output iiq_entry_t alu_issue_data,
  output logic       iiq_wakeup_valid,
  output rob_id_t    iiq_wakeup_rob_id,
  input  logic       alu_broadcast_valid,
  input  rob_id_t    alu_broadcast_rob_id,
  input  reg_data_t  alu_broadcast_reg_data,
  input  logic       ld_broadcast_valid,
  input  rob_id_t    ld_broadcast_rob_id,
  input  reg_data_t  ld_broadcast_reg_data,
  input  logic       fetch_redirect_valid
);

  localparam int c_IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam int c_CNT_W = $clog2(N_ENTRIES + 1);

  iiq_entry_t           r_entries [N_ENTRIES];
  logic [N_ENTRIES-1:0] r_valid;
  logic [c_CNT_W-1:0]   r_count;

  logic [N_ENTRIES-1:0] w_s1_rdy;
  logic [N_ENTRIES-1:0] w_s2_rdy;
  reg_data_t            w_s1_data [N_ENTRIES];
  reg_data_t            w_s2_data [N_ENTRIES];
  iiq_entry_t           w_upd     [N_ENTRIES];
  iiq_entry_t           w_nxt     [N_ENTRIES];
  logic [N_ENTRIES-1:0] w_nxt_valid;
  logic [N_ENTRIES-1:0] w_rdy;

  logic                 w_d1_rdy;
  logic                 w_d2_rdy;
  reg_data_t            w_d1_data;
  reg_data_t            w_d2_data;
  iiq_entry_t           w_disp_upd;

  logic                 w_found;
  logic [c_IDX_W-1:0]   w_sel;
  logic                 w_iss;
  logic                 w_enq;
  logic [c_CNT_W-1:0]   w_enq_idx;

  // One snoop per stored source; the wakeup is this cycle's own issue
  generate
    for (genvar g = 0; g < N_ENTRIES; g++) begin : g_entry
      iiq_src_snoop u_snoop_src1 (
        .i_src_valid    (r_entries[g].src1_valid),
        .i_src_ready    (r_entries[g].src1_ready),
        .i_src_rob_id   (r_entries[g].src1_rob_id),
        .i_src_data     (r_entries[g].src1_data),
        .i_wakeup_valid (iiq_wakeup_valid),
        .i_wakeup_rob_id(iiq_wakeup_rob_id),
        .i_alu_valid    (alu_broadcast_valid),
        .i_alu_rob_id   (alu_broadcast_rob_id),
        .i_alu_data     (alu_broadcast_reg_data),
        .i_ld_valid     (ld_broadcast_valid),
        .i_ld_rob_id    (ld_broadcast_rob_id),
        .i_ld_data      (ld_broadcast_reg_data),
        .o_next_ready   (w_s1_rdy[g]),
        .o_next_data    (w_s1_data[g])
      );
      iiq_src_snoop u_snoop_src2 (
        .i_src_valid    (r_entries[g].src2_valid),
        .i_src_ready    (r_entries[g].src2_ready),
        .i_src_rob_id   (r_entries[g].src2_rob_id),
        .i_src_data     (r_entries[g].src2_data),
        .i_wakeup_valid (iiq_wakeup_valid),
        .i_wakeup_rob_id(iiq_wakeup_rob_id),
        .i_alu_valid    (alu_broadcast_valid),
        .i_alu_rob_id   (alu_broadcast_rob_id),
        .i_alu_data     (alu_broadcast_reg_data),
        .i_ld_valid     (ld_broadcast_valid),
        .i_ld_rob_id    (ld_broadcast_rob_id),
        .i_ld_data      (ld_broadcast_reg_data),
        .o_next_ready   (w_s2_rdy[g]),
        .o_next_data    (w_s2_data[g])
      );
    end
  endgenerate

  iiq_src_snoop u_snoop_disp_src1 (
    .i_src_valid    (iiq_dispatch_data.src1_valid),
    .i_src_ready    (iiq_dispatch_data.src1_ready),
    .i_src_rob_id   (iiq_dispatch_data.src1_rob_id),
    .i_src_data     (iiq_dispatch_data.src1_data),
    .i_wakeup_valid (iiq_wakeup_valid),
    .i_wakeup_rob_id(iiq_wakeup_rob_id),
    .i_alu_valid    (alu_broadcast_valid),
    .i_alu_rob_id   (alu_broadcast_rob_id),
    .i_alu_data     (alu_broadcast_reg_data),
    .i_ld_valid     (ld_broadcast_valid),
    .i_ld_rob_id    (ld_broadcast_rob_id),
    .i_ld_data      (ld_broadcast_reg_data),
    .o_next_ready   (w_d1_rdy),
    .o_next_data    (w_d1_data)
  );

  iiq_src_snoop u_snoop_disp_src2 (
    .i_src_valid    (iiq_dispatch_data.src2_valid),
    .i_src_ready    (iiq_dispatch_data.src2_ready),
    .i_src_rob_id   (iiq_dispatch_data.src2_rob_id),
    .i_src_data     (iiq_dispatch_data.src2_data),
    .i_wakeup_valid (iiq_wakeup_valid),
    .i_wakeup_rob_id(iiq_wakeup_rob_id),
    .i_alu_valid    (alu_broadcast_valid),
    .i_alu_rob_id   (alu_broadcast_rob_id),
    .i_alu_data     (alu_broadcast_reg_data),
    .i_ld_valid     (ld_broadcast_valid),
    .i_ld_rob_id    (ld_broadcast_rob_id),
    .i_ld_data      (ld_broadcast_reg_data),
    .o_next_ready   (w_d2_rdy),
    .o_next_data    (w_d2_data)
  );

  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      w_upd[i]            = r_entries[i];
      w_upd[i].src1_ready = w_s1_rdy[i];
      w_upd[i].src1_data  = w_s1_data[i];
      w_upd[i].src2_ready = w_s2_rdy[i];
      w_upd[i].src2_data  = w_s2_data[i];
      w_rdy[i] = r_valid[i]
               && (!r_entries[i].src1_valid || r_entries[i].src1_ready)
               && (!r_entries[i].src2_valid || r_entries[i].src2_ready);
    end
    w_disp_upd            = iiq_dispatch_data;
    w_disp_upd.src1_ready = w_d1_rdy;
    w_disp_upd.src1_data  = w_d1_data;
    w_disp_upd.src2_ready = w_d2_rdy;
    w_disp_upd.src2_data  = w_d2_data;
  end

  // Oldest-first pick: scan downward so the lowest ready index wins
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (w_rdy[i]) begin
        w_found = 1'b1;
        w_sel   = c_IDX_W'(i);
      end
    end
  end

  assign iiq_dispatch_ready = (r_count < c_CNT_W'(N_ENTRIES));
  assign alu_issue_valid    = w_found && !fetch_redirect_valid;
  assign w_iss              = alu_issue_valid && alu_issue_ready;
  assign w_enq              = iiq_dispatch_valid && iiq_dispatch_ready && !fetch_redirect_valid;
  assign w_enq_idx          = r_count - c_CNT_W'(w_iss);
  assign iiq_wakeup_valid   = w_iss && r_entries[w_sel].dst_valid;
  assign iiq_wakeup_rob_id  = r_entries[w_sel].instr_rob_id;

  always_comb begin
    alu_issue_data           = r_entries[w_sel];
    alu_issue_data.src1_data = w_s1_data[w_sel];
    alu_issue_data.src2_data = w_s2_data[w_sel];
  end

  // Remove the issued slot, slide the younger entries down, then append
  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      w_nxt[i]       = w_upd[i];
      w_nxt_valid[i] = r_valid[i];
      if (w_iss && (i >= int'(w_sel))) begin
        if (i < N_ENTRIES - 1) begin
          w_nxt[i]       = w_upd[i+1];
          w_nxt_valid[i] = r_valid[i+1];
        end else begin
          w_nxt_valid[i] = 1'b0;
        end
      end
      if (w_enq && (i == int'(w_enq_idx))) begin
        w_nxt[i]       = w_disp_upd;
        w_nxt_valid[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || fetch_redirect_valid) begin
      r_valid <= '0;
      r_count <= '0;
    end else begin
      r_valid <= w_nxt_valid;
      r_count <= r_count + c_CNT_W'(w_enq) - c_CNT_W'(w_iss);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      r_entries[i] <= w_nxt[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_int_issue_queue.sv
`default_nettype none
// =============================================================================
// tb_int_issue_queue : directed self-checking bench for int_issue_queue
// Revision : 1.0
// =============================================================================
module tb_int_issue_queue;
  import int_issue_queue_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       iiq_dispatch_valid;
  logic       iiq_dispatch_ready;
  iiq_entry_t iiq_dispatch_data;
  logic       alu_issue_valid;
  logic       alu_issue_ready;
  iiq_entry_t alu_issue_data;
  logic       iiq_wakeup_valid;
  rob_id_t    iiq_wakeup_rob_id;
  logic       alu_broadcast_valid;
  rob_id_t    alu_broadcast_rob_id;
  reg_data_t  alu_broadcast_reg_data;
  logic       ld_broadcast_valid;
  rob_id_t    ld_broadcast_rob_id;
  reg_data_t  ld_broadcast_reg_data;
  logic       fetch_redirect_valid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  int_issue_queue #(.N_ENTRIES(8)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .iiq_dispatch_valid    (iiq_dispatch_valid),
    .iiq_dispatch_ready    (iiq_dispatch_ready),
    .iiq_dispatch_data     (iiq_dispatch_data),
    .alu_issue_valid       (alu_issue_valid),
    .alu_issue_ready       (alu_issue_ready),
    .alu_issue_data        (alu_issue_data),
    .iiq_wakeup_valid      (iiq_wakeup_valid),
    .iiq_wakeup_rob_id     (iiq_wakeup_rob_id),
    .alu_broadcast_valid   (alu_broadcast_valid),
    .alu_broadcast_rob_id  (alu_broadcast_rob_id),
    .alu_broadcast_reg_data(alu_broadcast_reg_data),
    .ld_broadcast_valid    (ld_broadcast_valid),
    .ld_broadcast_rob_id   (ld_broadcast_rob_id),
    .ld_broadcast_reg_data (ld_broadcast_reg_data),
    .fetch_redirect_valid  (fetch_redirect_valid)
  );

  function automatic iiq_entry_t mk(input rob_id_t rob, input logic dst,
                                    input logic s1v, input logic s1r, input rob_id_t s1id, input reg_data_t s1d,
                                    input logic s2v, input logic s2r, input rob_id_t s2id, input reg_data_t s2d);
    iiq_entry_t e;
    e = '0;
    e.instr_rob_id = rob;
    e.dst_valid    = dst;
    e.src1_valid   = s1v;
    e.src1_ready   = s1r;
    e.src1_rob_id  = s1id;
    e.src1_data    = s1d;
    e.src2_valid   = s2v;
    e.src2_ready   = s2r;
    e.src2_rob_id  = s2id;
    e.src2_data    = s2d;
    return e;
  endfunction

  // Inputs change 1 time unit after the rising edge, outputs are read 1 unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    iiq_dispatch_valid     = 1'b0;
    iiq_dispatch_data      = '0;
    alu_issue_ready        = 1'b0;
    alu_broadcast_valid    = 1'b0;
    alu_broadcast_rob_id   = '0;
    alu_broadcast_reg_data = '0;
    ld_broadcast_valid     = 1'b0;
    ld_broadcast_rob_id    = '0;
    ld_broadcast_reg_data  = '0;
    fetch_redirect_valid   = 1'b0;
  endtask

  task automatic dispatch_one(input iiq_entry_t e);
    iiq_dispatch_valid = 1'b1;
    iiq_dispatch_data  = e;
    step();
    iiq_dispatch_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    settle();
    n_vec++; if (iiq_dispatch_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", iiq_dispatch_ready); end
    n_vec++; if (alu_issue_valid !== 1'b0) begin n_err++; $display("FAIL reset_issue_valid: got %b want 0", alu_issue_valid); end
    n_vec++; if (iiq_wakeup_valid !== 1'b0) begin n_err++; $display("FAIL reset_wakeup_valid: got %b want 0", iiq_wakeup_valid); end
    step();
  endtask

  task automatic test_fill();
    alu_issue_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      iiq_dispatch_valid = 1'b1;
      iiq_dispatch_data  = mk(5'(k + 1), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      settle();
      n_vec++; if (iiq_dispatch_ready !== (k < 8)) begin n_err++; $display("FAIL fill_ready[%0d]: got %b want %b", k, iiq_dispatch_ready, (k < 8)); end
      if (k == 8) begin
        n_vec++; if (alu_issue_valid !== 1'b1 || alu_issue_data.instr_rob_id !== 5'd1) begin n_err++; $display("FAIL fill_held_issue: got v=%b rob=%0d want v=1 rob=1", alu_issue_valid, alu_issue_data.instr_rob_id); end
      end
      step();
    end
  endtask

  task automatic test_full_dispatch_issue();
    // queue holds rob 1..8 and rob 9 is still offered
    alu_issue_ready = 1'b1;
    settle();
    n_vec++; if (iiq_dispatch_ready !== 1'b0) begin n_err++; $display("FAIL full_noready: got %b want 0", iiq_dispatch_ready); end
    n_vec++; if (alu_issue_valid !== 1'b1 || alu_issue_data.instr_rob_id !== 5'd1) begin n_err++; $display("FAIL full_issue: got v=%b rob=%0d want v=1 rob=1", alu_issue_valid, alu_issue_data.instr_rob_id); end
    n_vec++; if (iiq_wakeup_valid !== 1'b1 || iiq_wakeup_rob_id !== 5'd1) begin n_err++; $display("FAIL full_wakeup: got v=%b rob=%0d want v=1 rob=1", iiq_wakeup_valid, iiq_wakeup_rob_id); end
    step();
    alu_issue_ready = 1'b0;
    settle();
    n_vec++; if (iiq_dispatch_ready !== 1'b1) begin n_err++; $display("FAIL full_count7_ready: got %b want 1", iiq_dispatch_ready); end
    step();
    iiq_dispatch_valid = 1'b0;
    settle();
    n_vec++; if (iiq_dispatch_ready !== 1'b0) begin n_err++; $display("FAIL full_count8_ready: got %b want 0", iiq_dispatch_ready); end
    alu_issue_ready = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      settle();
      n_vec++; if (alu_issue_valid !== 1'b1 || alu_issue_data.instr_rob_id !== 5'(k)) begin n_err++; $display("FAIL drain_order[%0d]: got v=%b rob=%0d want v=1 rob=%0d", k, alu_issue_valid, alu_issue_data.instr_rob_id, k); end
      step();
    end
    settle();
    n_vec++; if (alu_issue_valid !== 1'b0 || iiq_dispatch_ready !== 1'b1) begin n_err++; $display("FAIL drain_empty: got v=%b rdy=%b want v=0 rdy=1", alu_issue_valid, iiq_dispatch_ready); end
    alu_issue_ready = 1'b0;
    step();
  endtask

  task automatic test_age_order();
    alu_issue_ready = 1'b0;
    dispatch_one(mk(5'd10, 1'b0, 1'b1, 1'b0, 5'd5, 32'h55, 1'b0, 1'b0, 5'd0, 32'h0));
    dispatch_one(mk(5'd11, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0));
    settle();
    n_vec++; if (alu_issue_valid !== 1'b1 || alu_issue_data.instr_rob_id !== 5'd11) begin n_err++; $display("FAIL age_skip_idx0: got v=%b rob=%0d want v=1 rob=11", alu_issue_valid, alu_issue_data.instr_rob_id); end
    alu_issue_ready = 1'b1;
    step();
    settle();
    n_vec++; if (alu_issue_valid !== 1'b0) begin n_err++; $display("FAIL age_waiting: got %b want 0", alu_issue_valid); end
    // producer of rob 5 lands behind the waiting entry
    iiq_dispatch_valid = 1'b1;
    iiq_dispatch_data  = mk(5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    settle();
    n_vec++; if (alu_issue_valid !== 1'b0) begin n_err++; $display("FAIL age_no_dispatch_issue: got %b want 0", alu_issue_valid); end
    step();
    iiq_dispatch_valid = 1'b0;
    settle();
    n_vec++; if (alu_issue_valid !== 1'b1 || alu_issue_data.instr_rob_id !== 5'd5) begin n_err++; $display("FAIL age_producer: got v=%b rob=%0d want v=1 rob=5", alu_issue_valid, alu_issue_data.instr_rob_id); end
    n_vec++; if (iiq_wakeup_valid !== 1'b1 || iiq_wakeup_rob_id !== 5'd5) begin n_err++; $display("FAIL age_wakeup: got v=%b rob=%0d want v=1 rob=5", iiq_wakeup_valid, iiq_wakeup_rob_id); end
    step();
    settle();
    n_vec++; if (alu_issue_valid !== 1'b1 || alu_issue_data.instr_rob_id !== 5'd10 || alu_issue_data.src1_data !== 32'h55) begin n_err++; $display("FAIL age_idx0_woken: got v=%b rob=%0d d=%h want v=1 rob=10 d=00000055", alu_issue_valid, alu_issue_data.instr_rob_id, alu_issue_data.src1_data); end
    step();
    settle();
    n_vec++; if (alu_issue_valid !== 1'b0) begin n_err++; $display("FAIL age_empty: got %b want 0", alu_issue_valid); end
    alu_issue_ready = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    alu_issue_ready = 1'b0;
    dispatch_one(mk(5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0));
    dispatch_one(mk(5'd4, 1'b1, 1'b1, 1'b0, 5'd3, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0));
    alu_issue_ready = 1'b1;
    settle();
    n_vec++; if (alu_issue_valid !== 1'b1 || alu_issue_data.instr_rob_id !== 5'd3 || iiq_wakeup_valid !== 1'b1 || iiq_wakeup_rob_id !== 5'd3) begin n_err++; $display("FAIL b2b_producer: got v=%b rob=%0d wk=%b wkrob=%0d want 1/3/1/3", alu_issue_valid, alu_issue_data.instr_rob_id, iiq_wakeup_valid, iiq_wakeup_rob_id); end
    step();
    alu_broadcast_valid    = 1'b1;
    alu_broadcast_rob_id   = 5'd3;
    alu_broadcast_reg_data = 32'hDEADBEEF;
    settle();
    n_vec++; if (alu_issue_valid !== 1'b1 || alu_issue_data.instr_rob_id !== 5'd4) begin n_err++; $display("FAIL b2b_consumer: got v=%b rob=%0d want v=1 rob=4", alu_issue_valid, alu_issue_data.instr_rob_id); end
    n_vec++; if (alu_issue_data.src1_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL b2b_bypass: got %h want deadbeef", alu_issue_data.src1_data); end
    step();
    alu_broadcast_valid = 1'b0;
    settle();
    n_vec++; if (alu_issue_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got %b want 0", alu_issue_valid); end
    alu_issue_ready = 1'b0;
    step();
  endtask

  task automatic test_load_wakeup();
    alu_issue_ready = 1'b1;
    dispatch_one(mk(5'd12, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd9, 32'h0));
    ld_broadcast_valid    = 1'b1;
    ld_broadcast_rob_id   = 5'd9;
    ld_broadcast_reg_data = 32'h1234;
    settle();
    n_vec++; if (alu_issue_valid !== 1'b0) begin n_err++; $display("FAIL ld_not_yet: got %b want 0", alu_issue_valid); end
    step();
    ld_broadcast_valid = 1'b0;
    settle();
    n_vec++; if (alu_issue_valid !== 1'b1 || alu_issue_data.instr_rob_id !== 5'd12 || alu_issue_data.src2_data !== 32'h1234) begin n_err++; $display("FAIL ld_issue: got v=%b rob=%0d d=%h want v=1 rob=12 d=00001234", alu_issue_valid, alu_issue_data.instr_rob_id, alu_issue_data.src2_data); end
    step();
    alu_issue_ready = 1'b0;
    step();
  endtask

  task automatic test_flush();
    alu_issue_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      dispatch_one(mk(5'(20 + k), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0));
    end
    iiq_dispatch_valid   = 1'b1;
    iiq_dispatch_data    = mk(5'd25, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    alu_issue_ready      = 1'b1;
    fetch_redirect_valid = 1'b1;
    settle();
    n_vec++; if (alu_issue_valid !== 1'b0 || iiq_wakeup_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_issue: got v=%b wk=%b want 0/0", alu_issue_valid, iiq_wakeup_valid); end
    step();
    fetch_redirect_valid = 1'b0;
    iiq_dispatch_valid   = 1'b0;
    settle();
    n_vec++; if (alu_issue_valid !== 1'b0 || iiq_dispatch_ready !== 1'b1) begin n_err++; $display("FAIL flush_empty: got v=%b rdy=%b want 0/1", alu_issue_valid, iiq_dispatch_ready); end
    dispatch_one(mk(5'd26, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0));
    settle();
    n_vec++; if (alu_issue_valid !== 1'b1 || alu_issue_data.instr_rob_id !== 5'd26) begin n_err++; $display("FAIL flush_refill: got v=%b rob=%0d want v=1 rob=26", alu_issue_valid, alu_issue_data.instr_rob_id); end
    step();
    alu_issue_ready = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    alu_issue_ready = 1'b0;
    dispatch_one(mk(5'd30, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0));
    dispatch_one(mk(5'd31, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    alu_issue_ready = 1'b1;
    settle();
    n_vec++; if (alu_issue_valid !== 1'b0 || iiq_wakeup_valid !== 1'b0 || iiq_dispatch_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid: got v=%b wk=%b rdy=%b want 0/0/1", alu_issue_valid, iiq_wakeup_valid, iiq_dispatch_ready); end
    step();
    settle();
    n_vec++; if (alu_issue_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_later: got %b want 0", alu_issue_valid); end
    alu_issue_ready = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_dispatch_issue();
    test_age_order();
    test_back_to_back();
    test_load_wakeup();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
